// File: rtl/fifo_traffic_checker.sv
// rtl/fifo_traffic_checker.sv - pattern-driven write/read traffic checker for a FIFO under test
//
// Writes num_words pattern words into a FIFO, reads them back with a
// programmable read throttle, and compares each read word against an
// independently advanced copy of the same pattern generator.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              one-cycle pulse that begins a run (ignored while busy)
//   mode               0 = increment pattern, 1 = rotate-left pattern
//   num_words          words to write and read per run
//   rd_period          idle cycles between read attempts
//   full, empty        FIFO status
//   rdata              FIFO read data, valid the cycle after ren
//   wen, wdata         FIFO write port
//   ren                FIFO read enable
//   busy, done         run in progress / run complete
//   err, err_cnt       sticky mismatch flag and saturating mismatch count
//   first_err_idx      read index of the first mismatch
//   wr_cnt, rd_cnt     words written / compared this run
module fifo_traffic_checker #(
    parameter int          DW    = 64,
    parameter logic [63:0] SEED  = 64'h1234_5678,
    parameter int          CNT_W = 32,
    parameter int          PER_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_words,
    input  logic [PER_W-1:0] rd_period,
    input  logic             full,
    input  logic             empty,
    input  logic [DW-1:0]    rdata,
    output logic             wen,
    output logic [DW-1:0]    wdata,
    output logic             ren,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [DW-1:0]    SEED_W  = DW'(SEED);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [DW-1:0]      wgen_q, wgen_d;
    logic [DW-1:0]      egen_q, egen_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   iss_q, iss_d;       // reads issued (rd_cnt lags by one cycle)
    logic [PER_W-1:0]   thr_q, thr_d;
    logic               cmp_q, cmp_d;       // a read was issued last cycle
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   fei_q, fei_d;
    logic               wen_c, ren_c;

    function automatic logic [DW-1:0] advance(input logic [DW-1:0] g, input logic m);
        return m ? {g[DW-2:0], g[DW-1]} : g + DW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        per_d     = per_q;
        wgen_d    = wgen_q;
        egen_d    = egen_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        iss_d     = iss_q;
        thr_d     = thr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        fei_d     = fei_q;

        wen_c = (state_q == S_RUN) && !full && (wr_cnt_q < num_q);
        ren_c = (state_q == S_RUN) && !empty && (thr_q == per_q) && (iss_q < num_q);
        cmp_d = ren_c;

        // Compare the word returned for last cycle's read.
        if (cmp_q) begin
            egen_d   = advance(egen_q, mode_q);
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rdata != egen_q) begin
                err_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (!err_q) begin
                    fei_d = rd_cnt_q;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d    = mode;
                    num_d     = num_words;
                    per_d     = rd_period;
                    wgen_d    = SEED_W;
                    egen_d    = SEED_W;
                    wr_cnt_d  = '0;
                    rd_cnt_d  = '0;
                    iss_d     = '0;
                    thr_d     = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    fei_d     = '0;
                    state_d   = (num_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (wen_c) begin
                    wgen_d   = advance(wgen_q, mode_q);
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
                if (ren_c) begin
                    thr_d = '0;
                    iss_d = iss_q + CNT_W'(1);
                    if (iss_q + CNT_W'(1) == num_q) begin
                        state_d = S_DRAIN;
                    end
                end else if (thr_q != per_q) begin
                    thr_d = thr_q + PER_W'(1);
                end
            end
            S_DRAIN: begin
                // The final read's compare happens in this cycle.
                if (cmp_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            num_q     <= '0;
            per_q     <= '0;
            wgen_q    <= '0;
            egen_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            iss_q     <= '0;
            thr_q     <= '0;
            cmp_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            fei_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            per_q     <= per_d;
            wgen_q    <= wgen_d;
            egen_q    <= egen_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            iss_q     <= iss_d;
            thr_q     <= thr_d;
            cmp_q     <= cmp_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            fei_q     <= fei_d;
        end
    end

    assign wen           = wen_c;
    assign ren           = ren_c;
    assign wdata         = wgen_q;
    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = fei_q;
    assign wr_cnt        = wr_cnt_q;
    assign rd_cnt        = rd_cnt_q;

endmodule
